// File: rtl/speicher_arbiter_if.sv
// rtl/speicher_arbiter_if.sv - CPU fetch/data ports and unified RAM port of the speicher arbiter
interface speicher_arbiter_if #(
   parameter int ADRESSBREITE = 8,
   parameter int WORTBREITE   = 32
);
   logic                    LeseInstruktion;
   logic [31:0]             InstruktionAdresse;
   logic [WORTBREITE-1:0]   Instruktion;
   logic                    InstruktionGeladen;
   logic                    LeseDaten;
   logic                    SchreibeDaten;
   logic [31:0]             DatenAdresse;
   logic [WORTBREITE-1:0]   DatenRaus;
   logic [WORTBREITE-1:0]   DatenRein;
   logic                    DatenGeladen;
   logic                    DatenGespeichert;
   logic                    RAMLesenAn;
   logic                    RAMSchreibenAn;
   logic [ADRESSBREITE-1:0] RAMAdresse;
   logic [WORTBREITE-1:0]   RAMDatenRein;
   logic [WORTBREITE-1:0]   RAMDatenRaus;
   logic                    RAMDatenBereit;
   logic                    RAMDatenGeschrieben;
   logic                    Fehler;

   modport slave (
      input  LeseInstruktion,
      input  InstruktionAdresse,
      output Instruktion,
      output InstruktionGeladen,
      input  LeseDaten,
      input  SchreibeDaten,
      input  DatenAdresse,
      input  DatenRaus,
      output DatenRein,
      output DatenGeladen,
      output DatenGespeichert,
      output RAMLesenAn,
      output RAMSchreibenAn,
      output RAMAdresse,
      output RAMDatenRein,
      input  RAMDatenRaus,
      input  RAMDatenBereit,
      input  RAMDatenGeschrieben,
      output Fehler
   );

   modport master (
      output LeseInstruktion,
      output InstruktionAdresse,
      input  Instruktion,
      input  InstruktionGeladen,
      output LeseDaten,
      output SchreibeDaten,
      output DatenAdresse,
      output DatenRaus,
      input  DatenRein,
      input  DatenGeladen,
      input  DatenGespeichert,
      input  RAMLesenAn,
      input  RAMSchreibenAn,
      input  RAMAdresse,
      input  RAMDatenRein,
      output RAMDatenRaus,
      output RAMDatenBereit,
      output RAMDatenGeschrieben,
      input  Fehler
   );
endinterface

// File: rtl/speicher_arbiter.sv
// rtl/speicher_arbiter.sv - shares one single-port RAM between instruction fetch and data port
// Optional feature macro: SPEICHER_ARBITER_ROUNDROBIN_EN (round-robin instead of data-first priority)
module speicher_arbiter #(
   parameter int ADRESSBREITE = 8,
   parameter int WORTBREITE   = 32,
   parameter int TIMEOUT      = 64
) (
   input logic               Clock,
   input logic               Reset,
   speicher_arbiter_if.slave bus
);
   typedef enum logic [2:0] {
      LEERLAUF,
      INSTR,
      DATEN_LESEN,
      DATEN_SCHREIBEN,
      FREIGABE
   } zustand_t;

   localparam int ZAEHLERBREITE = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   zustand_t                 zustand;
   zustand_t                 folgeZustand;
   logic [ZAEHLERBREITE-1:0] waechter;

   logic                     anfrageI;
   logic                     anfrageD;
   logic                     datenGewinnt;
   logic                     vergeben;
   logic                     strobe;
   logic                     abgelaufen;
   logic                     fertig;

   logic                     uebernehmen;
   logic                     lesenAnNeu;
   logic                     schreibenAnNeu;
   logic                     ackINeu;
   logic                     ackDLNeu;
   logic                     ackDSNeu;
   logic                     fehlerNeu;

   logic                     lesenAn;
   logic                     schreibenAn;
   logic [ADRESSBREITE-1:0]  adresse;
   logic [WORTBREITE-1:0]    schreibDaten;
   logic [WORTBREITE-1:0]    instruktion;
   logic [WORTBREITE-1:0]    datenRein;
   logic                     ackI;
   logic                     ackDL;
   logic                     ackDS;
   logic                     fehler;

   // Only the low address bits select a RAM word; I/O decoding happens upstream.
   logic                     unusedAdressBits;
   assign unusedAdressBits = ^{bus.InstruktionAdresse[31:ADRESSBREITE],
                               bus.DatenAdresse[31:ADRESSBREITE]};

   assign anfrageI   = bus.LeseInstruktion;
   assign anfrageD   = bus.LeseDaten | bus.SchreibeDaten;
   assign vergeben   = (zustand == INSTR) || (zustand == DATEN_LESEN) ||
                       (zustand == DATEN_SCHREIBEN);
   assign strobe     = vergeben && ((zustand == DATEN_SCHREIBEN) ? bus.RAMDatenGeschrieben
                                                                 : bus.RAMDatenBereit);
   assign abgelaufen = vergeben && (TIMEOUT != 0) &&
                       (waechter == ZAEHLERBREITE'(TIMEOUT - 1));
   assign fertig     = strobe || abgelaufen;

`ifdef SPEICHER_ARBITER_ROUNDROBIN_EN
   // Pointer names the port that wins the next conflict; it moves away from whoever was just served.
   logic zeigerDaten;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         zeigerDaten <= 1'b1;
      end else if (fertig) begin
         zeigerDaten <= (zustand == INSTR);
      end
   end

   assign datenGewinnt = zeigerDaten;
`else
   assign datenGewinnt = 1'b1;
`endif

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         zustand <= LEERLAUF;
      end else begin
         zustand <= folgeZustand;
      end
   end

   always_comb begin
      folgeZustand = zustand;
      case (zustand)
         LEERLAUF: begin
            if (anfrageD && (!anfrageI || datenGewinnt)) begin
               folgeZustand = bus.SchreibeDaten ? DATEN_SCHREIBEN : DATEN_LESEN;
            end else if (anfrageI) begin
               folgeZustand = INSTR;
            end
         end
         INSTR, DATEN_LESEN, DATEN_SCHREIBEN: begin
            if (fertig) begin
               folgeZustand = FREIGABE;
            end
         end
         FREIGABE: folgeZustand = LEERLAUF;
         default:  folgeZustand = LEERLAUF;
      endcase
   end

   always_comb begin
      uebernehmen    = 1'b0;
      lesenAnNeu     = 1'b0;
      schreibenAnNeu = 1'b0;
      ackINeu        = 1'b0;
      ackDLNeu       = 1'b0;
      ackDSNeu       = 1'b0;
      fehlerNeu      = abgelaufen && !strobe;
      case (zustand)
         LEERLAUF: begin
            uebernehmen    = (folgeZustand != LEERLAUF);
            lesenAnNeu     = (folgeZustand == INSTR) || (folgeZustand == DATEN_LESEN);
            schreibenAnNeu = (folgeZustand == DATEN_SCHREIBEN);
         end
         INSTR: begin
            lesenAnNeu = !fertig;
            ackINeu    = fertig;
         end
         DATEN_LESEN: begin
            lesenAnNeu = !fertig;
            ackDLNeu   = fertig;
         end
         DATEN_SCHREIBEN: begin
            schreibenAnNeu = !fertig;
            ackDSNeu       = fertig;
         end
         default: begin
         end
      endcase
   end

   // A real RAM answer takes precedence over a watchdog expiry in the same cycle.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         lesenAn      <= 1'b0;
         schreibenAn  <= 1'b0;
         adresse      <= '0;
         schreibDaten <= '0;
         instruktion  <= '0;
         datenRein    <= '0;
         ackI         <= 1'b0;
         ackDL        <= 1'b0;
         ackDS        <= 1'b0;
         fehler       <= 1'b0;
         waechter     <= '0;
      end else begin
         lesenAn     <= lesenAnNeu;
         schreibenAn <= schreibenAnNeu;
         ackI        <= ackINeu;
         ackDL       <= ackDLNeu;
         ackDS       <= ackDSNeu;
         if (uebernehmen) begin
            adresse      <= (folgeZustand == INSTR) ? bus.InstruktionAdresse[ADRESSBREITE-1:0]
                                                    : bus.DatenAdresse[ADRESSBREITE-1:0];
            schreibDaten <= bus.DatenRaus;
            waechter     <= '0;
         end else if (vergeben && !fertig) begin
            waechter <= waechter + 1'b1;
         end
         if (ackINeu) begin
            instruktion <= strobe ? bus.RAMDatenRaus : '0;
         end
         if (ackDLNeu) begin
            datenRein <= strobe ? bus.RAMDatenRaus : '0;
         end
         if (fehlerNeu) begin
            fehler <= 1'b1;
         end
      end
   end

   assign bus.RAMLesenAn         = lesenAn;
   assign bus.RAMSchreibenAn     = schreibenAn;
   assign bus.RAMAdresse         = adresse;
   assign bus.RAMDatenRein       = schreibDaten;
   assign bus.Instruktion        = instruktion;
   assign bus.InstruktionGeladen = ackI;
   assign bus.DatenRein          = datenRein;
   assign bus.DatenGeladen       = ackDL;
   assign bus.DatenGespeichert   = ackDS;
   assign bus.Fehler             = fehler;

endmodule

// File: tb/tb_speicher_arbiter.sv
// tb/tb_speicher_arbiter.sv - scoreboard bench for speicher_arbiter with a behavioural RAM and reference memory
module tb_speicher_arbiter;
   localparam int AB = 8;
   localparam int WB = 32;
   localparam int TO = 4;

   logic Clock = 1'b0;
   logic Reset;
   always #5 Clock = ~Clock;

   speicher_arbiter_if #(.ADRESSBREITE(AB), .WORTBREITE(WB)) bus ();

   speicher_arbiter #(.ADRESSBREITE(AB), .WORTBREITE(WB), .TIMEOUT(TO)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   typedef struct {
      logic        isWrite;
      logic [31:0] val;
   } datExp_t;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   logic [31:0] ramArr [256];
   logic [31:0] refMem [256];
   logic        ramMute  = 1'b0;
   logic [31:0] instrQ [$];
   datExp_t     datenQ [$];
   int          servedLog [$];

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic fehlschlag(input string name, input string info);
      checks++;
      failures++;
      $display("FAIL %s: %s", name, info);
   endtask

   function automatic logic [31:0] initWort(input int i);
      return (i == 5) ? 32'hDEADBEEF : ((32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000);
   endfunction

   // Behavioural RAM: answers a held enable after a random 0..2 cycle latency unless muted.
   initial begin
      int          warte;
      int          lat;
      logic [7:0]  ersteAdr;
      warte    = 0;
      lat      = 0;
      ersteAdr = '0;
      for (int i = 0; i < 256; i++) begin
         ramArr[i] = initWort(i);
         refMem[i] = initWort(i);
      end
      bus.RAMDatenBereit      = 1'b0;
      bus.RAMDatenGeschrieben = 1'b0;
      bus.RAMDatenRaus        = '0;
      forever begin
         @(posedge Clock);
         #1;
         if (Reset) begin
            bus.RAMDatenBereit      = 1'b0;
            bus.RAMDatenGeschrieben = 1'b0;
            warte = 0;
         end else if (bus.RAMDatenBereit || bus.RAMDatenGeschrieben) begin
            bus.RAMDatenBereit      = 1'b0;
            bus.RAMDatenGeschrieben = 1'b0;
            bus.RAMDatenRaus        = $urandom;
            warte = 0;
            lat   = $urandom_range(0, 2);
         end else if ((bus.RAMLesenAn || bus.RAMSchreibenAn) && !ramMute) begin
            if (warte == 0) ersteAdr = bus.RAMAdresse;
            if (warte >= lat) begin
               check("ram_addr_stable", 32'(bus.RAMAdresse), 32'(ersteAdr));
               if (bus.RAMSchreibenAn) begin
                  ramArr[bus.RAMAdresse]  = bus.RAMDatenRein;
                  bus.RAMDatenGeschrieben = 1'b1;
               end else begin
                  bus.RAMDatenRaus   = ramArr[bus.RAMAdresse];
                  bus.RAMDatenBereit = 1'b1;
               end
            end else begin
               warte++;
            end
         end else begin
            warte = 0;
         end
      end
   end

   // Monitor: every ack must match the oldest expectation of its port.
   always @(negedge Clock) begin
      if (!Reset) begin
         if (bus.RAMLesenAn || bus.RAMSchreibenAn)
            check("single_enable", 32'(bus.RAMLesenAn & bus.RAMSchreibenAn), 32'd0);
         if (bus.InstruktionGeladen) begin
            servedLog.push_back(0);
            if (instrQ.size() == 0) fehlschlag("instr_ack_unexpected", "no fetch outstanding");
            else check("instruktion", bus.Instruktion, instrQ.pop_front());
         end
         if (bus.DatenGeladen && bus.DatenGespeichert) fehlschlag("data_double_ack", "both data acks high");
         if (bus.DatenGeladen || bus.DatenGespeichert) begin
            servedLog.push_back(1);
            if (datenQ.size() == 0) begin
               fehlschlag("data_ack_unexpected", "no data access outstanding");
            end else begin
               datExp_t e;
               e = datenQ.pop_front();
               check("data_ack_kind", 32'(bus.DatenGespeichert), 32'(e.isWrite));
               if (!e.isWrite) check("daten_rein", bus.DatenRein, e.val);
            end
         end
      end
   end

   task automatic holeInstruktion(input logic [31:0] adr, input logic [31:0] erwartet,
                                  input int pause, input bit pruefe);
      int n;
      instrQ.push_back(erwartet);
      bus.InstruktionAdresse = adr;
      bus.LeseInstruktion    = 1'b1;
      if (pruefe) begin
         @(posedge Clock);
         #1;
         check("fetch_grant_enable", 32'(bus.RAMLesenAn), 32'd1);
         check("fetch_grant_addr", 32'(bus.RAMAdresse), 32'(adr[7:0]));
      end
      n = 0;
      do begin
         @(posedge Clock);
         #1;
         n++;
      end while (!bus.InstruktionGeladen && n < 200);
      if (!bus.InstruktionGeladen) fehlschlag("fetch_ack_timeout", "no InstruktionGeladen in 200 cycles");
      if (pause > 0) begin
         bus.LeseInstruktion = 1'b0;
         repeat (pause) @(posedge Clock);
         #1;
         if (pruefe) check("fetch_ack_pulse_len", 32'(bus.InstruktionGeladen), 32'd0);
      end
   endtask

   task automatic datenZugriff(input bit schreib, input bit beide, input logic [31:0] adr,
                               input logic [31:0] wert, input int pause, input bit pruefe);
      int      n;
      datExp_t e;
      if (schreib || beide) begin
         refMem[adr[7:0]] = wert;
         e.isWrite = 1'b1;
         e.val     = wert;
      end else begin
         e.isWrite = 1'b0;
         e.val     = refMem[adr[7:0]];
      end
      datenQ.push_back(e);
      bus.DatenAdresse  = adr;
      bus.DatenRaus     = wert;
      bus.SchreibeDaten = schreib || beide;
      bus.LeseDaten     = !schreib || beide;
      if (pruefe) begin
         @(posedge Clock);
         #1;
         check("data_grant_write_en", 32'(bus.RAMSchreibenAn), 32'(schreib || beide));
         check("data_grant_read_en", 32'(bus.RAMLesenAn), 32'(!(schreib || beide)));
         check("data_grant_addr", 32'(bus.RAMAdresse), 32'(adr[7:0]));
      end
      n = 0;
      do begin
         @(posedge Clock);
         #1;
         n++;
      end while (!(bus.DatenGeladen || bus.DatenGespeichert) && n < 200);
      if (!(bus.DatenGeladen || bus.DatenGespeichert)) fehlschlag("data_ack_timeout", "no data ack in 200 cycles");
      if (pause > 0) begin
         bus.LeseDaten     = 1'b0;
         bus.SchreibeDaten = 1'b0;
         repeat (pause) @(posedge Clock);
         #1;
      end
   endtask

   task automatic doReset();
      bus.LeseInstruktion = 1'b0;
      bus.LeseDaten       = 1'b0;
      bus.SchreibeDaten   = 1'b0;
      Reset = 1'b1;
      repeat (2) @(posedge Clock);
      #3;
      Reset = 1'b0;
      @(posedge Clock);
      #1;
   endtask

   initial begin
      int          n;
      int          t0;
      int          pI;
      int          pD;
      bit          zeigerD;
      bit          winD;
      int          erwartetOrder [$];
      logic [31:0] adr;

      Reset = 1'b1;
      bus.LeseInstruktion    = 1'b0;
      bus.InstruktionAdresse = '0;
      bus.LeseDaten          = 1'b0;
      bus.SchreibeDaten      = 1'b0;
      bus.DatenAdresse       = '0;
      bus.DatenRaus          = '0;
      repeat (2) @(posedge Clock);
      #1;
      check("reset_instruktion", bus.Instruktion, 32'd0);
      check("reset_datenrein", bus.DatenRein, 32'd0);
      check("reset_acks", {29'd0, bus.InstruktionGeladen, bus.DatenGeladen, bus.DatenGespeichert}, 32'd0);
      check("reset_enables", {30'd0, bus.RAMLesenAn, bus.RAMSchreibenAn}, 32'd0);
      check("reset_ram_addr", 32'(bus.RAMAdresse), 32'd0);
      check("reset_ram_wdata", bus.RAMDatenRein, 32'd0);
      check("reset_fehler", 32'(bus.Fehler), 32'd0);
      #2;
      Reset = 1'b0;
      @(posedge Clock);
      #1;

      holeInstruktion(32'h0000_0005, 32'hDEADBEEF, 1, 1'b1);
      datenZugriff(1'b1, 1'b0, 32'h0000_0020, 32'h12345678, 1, 1'b1);
      datenZugriff(1'b0, 1'b0, 32'h0000_0020, 32'h0, 1, 1'b1);
      check("fehler_after_rw", 32'(bus.Fehler), 32'd0);
      datenZugriff(1'b0, 1'b1, 32'h0012_3440, 32'hCAFEF00D, 1, 1'b1);
      datenZugriff(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1, 1'b0);

      // Conflict: both ports issue two back-to-back requests starting in the same cycle.
      doReset();
      servedLog.delete();
      pI = 2;
      pD = 2;
      zeigerD = 1'b1;
      while (pI > 0 || pD > 0) begin
`ifdef SPEICHER_ARBITER_ROUNDROBIN_EN
         winD = (pI > 0 && pD > 0) ? zeigerD : (pD > 0);
`else
         winD = (pD > 0);
`endif
         erwartetOrder.push_back(winD ? 1 : 0);
         if (winD) pD--;
         else pI--;
         zeigerD = !winD;
      end
      fork
         begin
            holeInstruktion(32'h0000_0011, refMem[8'h11], 0, 1'b0);
            holeInstruktion(32'h0000_0012, refMem[8'h12], 1, 1'b0);
         end
         begin
            datenZugriff(1'b0, 1'b0, 32'h0000_0090, 32'h0, 0, 1'b0);
            datenZugriff(1'b0, 1'b0, 32'h0000_0091, 32'h0, 1, 1'b0);
         end
      join
      check("conflict_count", 32'(servedLog.size()), 32'(erwartetOrder.size()));
      for (int i = 0; i < erwartetOrder.size() && i < servedLog.size(); i++)
         check("conflict_order", 32'(servedLog[i]), 32'(erwartetOrder[i]));

      // Random traffic on both ports; fetches stay below 0x80, data writes above.
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               adr = {1'b0, 23'($urandom), 1'b0, 7'($urandom)};
               holeInstruktion(adr, refMem[adr[7:0]], $urandom_range(0, 3), 1'b0);
            end
            bus.LeseInstruktion = 1'b0;
         end
         begin
            for (int i = 0; i < 40; i++) begin
               if ($urandom_range(0, 1) == 1) begin
                  adr = {1'b0, 23'($urandom), 1'b1, 7'($urandom)};
                  datenZugriff(1'b1, $urandom_range(0, 3) == 0, adr, $urandom, $urandom_range(0, 3), 1'b0);
               end else begin
                  adr = {1'b0, 23'($urandom), 8'($urandom)};
                  datenZugriff(1'b0, 1'b0, adr, 32'h0, $urandom_range(0, 3), 1'b0);
               end
            end
            bus.LeseDaten     = 1'b0;
            bus.SchreibeDaten = 1'b0;
         end
      join
      repeat (3) @(posedge Clock);
      #1;
      check("random_fehler", 32'(bus.Fehler), 32'd0);
      check("instr_queue_empty", 32'(instrQ.size()), 32'd0);
      check("data_queue_empty", 32'(datenQ.size()), 32'd0);

      // Watchdog: RAM silent, fetch aborts TIMEOUT cycles after grant with data 0.
      ramMute = 1'b1;
      instrQ.push_back(32'h0);
      bus.InstruktionAdresse = 32'h0000_0009;
      bus.LeseInstruktion    = 1'b1;
      n = 0;
      do begin
         @(posedge Clock);
         #1;
         n++;
      end while (!bus.RAMLesenAn && n < 50);
      t0 = cyc;
      n = 0;
      do begin
         @(posedge Clock);
         #1;
         n++;
      end while (!bus.InstruktionGeladen && n < 50);
      if (!bus.InstruktionGeladen) fehlschlag("timeout_ack_missing", "no abort ack");
      check("timeout_latency", 32'(cyc - t0), 32'(TO));
      check("timeout_fehler_set", 32'(bus.Fehler), 32'd1);
      bus.LeseInstruktion = 1'b0;
      ramMute = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      holeInstruktion(32'h0000_000A, refMem[8'h0A], 2, 1'b1);
      check("timeout_fehler_sticky", 32'(bus.Fehler), 32'd1);

      // Reset in the middle of a write grant.
      ramMute = 1'b1;
      bus.DatenAdresse  = 32'h0000_0030;
      bus.DatenRaus     = 32'hA5A5A5A5;
      bus.SchreibeDaten = 1'b1;
      n = 0;
      do begin
         @(posedge Clock);
         #1;
         n++;
      end while (!bus.RAMSchreibenAn && n < 50);
      @(negedge Clock);
      #2;
      Reset = 1'b1;
      #1;
      check("reset_async_write_en", 32'(bus.RAMSchreibenAn), 32'd0);
      check("reset_no_write_ack", 32'(bus.DatenGespeichert), 32'd0);
      bus.SchreibeDaten = 1'b0;
      ramMute = 1'b0;
      @(posedge Clock);
      #3;
      Reset = 1'b0;
      @(posedge Clock);
      #1;
      check("reset_clears_fehler", 32'(bus.Fehler), 32'd0);
      holeInstruktion(32'h0000_0007, refMem[8'h07], 2, 1'b1);
      check("final_instr_queue_empty", 32'(instrQ.size()), 32'd0);
      check("final_data_queue_empty", 32'(datenQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "global timeout");
   end

endmodule
